// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-aware round-robin AXI-Stream arbiter with source channel tag
module axis_pkt_rr_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int KEEP_W     = TDATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             s_tvalid,
    output logic [NUM_CH-1:0]             s_tready,
    input  logic [NUM_CH*TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]      s_tkeep,
    input  logic [NUM_CH-1:0]             s_tlast,
    input  logic [NUM_CH*TUSER_WIDTH-1:0] s_tuser,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [TDATA_WIDTH-1:0]        m_tdata,
    output logic [KEEP_W-1:0]             m_tkeep,
    output logic                          m_tlast,
    output logic [TUSER_WIDTH-1:0]        m_tuser,
    output logic [CH_W-1:0]               m_chan,
    output logic                          busy,
    output logic                          pkt_done
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [CH_W-1:0]   gnt;
    logic [CH_W-1:0]   ptr;

    logic [NUM_CH-1:0] req;
    logic              req_any;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   sel;
    logic              sel_valid;
    int                idx;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    assign req     = s_tvalid & ch_en;
    assign req_any = |req;

    // Rotating priority scan: the lowest offset from ptr with a request wins; ptr when nothing requests
    always_comb begin
        win = ptr;
        idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (req[CH_W'(idx)]) begin
                win = CH_W'(idx);
            end
        end
    end

    // Selected channel: frozen grant once locked, otherwise the combinational winner
    always_comb begin
        sel       = (state == LOCKED) ? gnt : win;
        sel_valid = (state == LOCKED) || req_any;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tuser   = '0;
        s_tready  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == CH_W'(i)) begin
                m_tvalid = s_tvalid[i];
                m_tlast  = s_tlast[i];
                m_tdata  = s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
                m_tkeep  = s_tkeep[i*KEEP_W +: KEEP_W];
                m_tuser  = s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
                s_tready[i] = m_tready && sel_valid && !rst;
            end
        end
        if ((state == IDLE) && !req_any) begin
            m_tvalid = 1'b0;
        end
        if (rst) begin
            m_tvalid = 1'b0;
        end
    end

    assign m_chan = sel;
    assign busy   = (state == LOCKED);

    // Arbitration FSM: lock onto a winner until its tlast handshake, then advance the pointer past it
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= m_tvalid && m_tready && m_tlast;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (m_tready && m_tlast) begin
                            ptr <= next_ch(win);
                        end else begin
                            state <= LOCKED;
                            gnt   <= win;
                        end
                    end
                end
                LOCKED: begin
                    if (m_tvalid && m_tready && m_tlast) begin
                        state <= IDLE;
                        ptr   <= next_ch(gnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb/tb_axis_pkt_rr_arbiter.sv - directed vector bench for axis_pkt_rr_arbiter
module tb_axis_pkt_rr_arbiter;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int UW = 10;
    localparam int KW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     ch_en;
    logic [NC-1:0]     s_tvalid;
    logic [NC-1:0]     s_tready;
    logic [NC*DW-1:0]  s_tdata;
    logic [NC*KW-1:0]  s_tkeep;
    logic [NC-1:0]     s_tlast;
    logic [NC*UW-1:0]  s_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [UW-1:0]     m_tuser;
    logic [1:0]        m_chan;
    logic              busy;
    logic              pkt_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_pkt_rr_arbiter #(.NUM_CH(NC), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_chan(m_chan), .busy(busy), .pkt_done(pkt_done)
    );

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic [7:0] tag;
        logic       e_mv;
        logic [1:0] e_ch;
        logic [3:0] e_str;
        logic       e_ml;
        logic       e_busy;
        logic       e_pd;
    } vec_t;

    vec_t vq[$];

    function automatic logic [DW-1:0] mk_data(input int ch, input logic [7:0] tag);
        return {8'hA5, 8'(ch), tag, 8'(ch) ^ tag};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int ch, input logic [7:0] tag);
        return 4'(ch) ^ tag[3:0] ^ 4'h9;
    endfunction

    function automatic logic [UW-1:0] mk_user(input int ch, input logic [7:0] tag);
        return {2'(ch), tag};
    endfunction

    task automatic add(input logic r, input logic [3:0] en, input logic [3:0] vld, input logic [3:0] lst,
                       input logic rdy, input logic [7:0] tag, input logic mv, input logic [1:0] ch,
                       input logic [3:0] str, input logic ml, input logic bz, input logic pd);
        vec_t v;
        v.rst = r; v.en = en; v.vld = vld; v.lst = lst; v.rdy = rdy; v.tag = tag;
        v.e_mv = mv; v.e_ch = ch; v.e_str = str; v.e_ml = ml; v.e_busy = bz; v.e_pd = pd;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] en, input logic [3:0] vld, input logic [3:0] lst,
                         input logic rdy, input logic [7:0] tag);
        rst = r; ch_en = en; s_tvalid = vld; s_tlast = lst; m_tready = rdy;
        for (int i = 0; i < NC; i++) begin
            s_tdata[i*DW +: DW] = mk_data(i, tag);
            s_tkeep[i*KW +: KW] = mk_keep(i, tag);
            s_tuser[i*UW +: UW] = mk_user(i, tag);
        end
    endtask

    task automatic chk(input string name, input int vi, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, vi, act, exp);
        end
    endtask

    initial begin
        logic seen;
        drive(1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
        #1;

        // reset with all channels valid: nothing leaks out
        add(1, 4'hF, 4'hF, 4'h0, 1, 8'h00,  0, 0, 4'h0, 0, 0, 0);
        // ch2 alone, 3-beat packet
        add(0, 4'hF, 4'h4, 4'h0, 1, 8'h01,  1, 2, 4'h4, 0, 0, 0);
        add(0, 4'hF, 4'h4, 4'h0, 1, 8'h02,  1, 2, 4'h4, 0, 1, 0);
        add(0, 4'hF, 4'h4, 4'h4, 1, 8'h03,  1, 2, 4'h4, 1, 1, 0);
        add(0, 4'hF, 4'h0, 4'h0, 1, 8'h04,  0, 3, 4'h0, 0, 0, 1);
        add(0, 4'hF, 4'h0, 4'h0, 1, 8'h05,  0, 3, 4'h0, 0, 0, 0);
        // all channels valid, single-beat packets, ptr starts at 3 and wraps
        add(0, 4'hF, 4'hF, 4'hF, 1, 8'h06,  1, 3, 4'h8, 1, 0, 0);
        add(0, 4'hF, 4'hF, 4'hF, 1, 8'h07,  1, 0, 4'h1, 1, 0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 1, 8'h08,  1, 1, 4'h2, 1, 0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 1, 8'h09,  1, 2, 4'h4, 1, 0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 1, 8'h0A,  1, 3, 4'h8, 1, 0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 1, 8'h0B,  1, 0, 4'h1, 1, 0, 1);
        add(0, 4'hF, 4'h0, 4'h0, 1, 8'h0C,  0, 1, 4'h0, 0, 0, 1);
        // ch0 4-beat packet, ch1 requests from beat 2 and follows right after tlast
        add(0, 4'hF, 4'h1, 4'h0, 1, 8'h0D,  1, 0, 4'h1, 0, 0, 0);
        add(0, 4'hF, 4'h3, 4'h0, 1, 8'h0E,  1, 0, 4'h1, 0, 1, 0);
        add(0, 4'hF, 4'h3, 4'h0, 1, 8'h0F,  1, 0, 4'h1, 0, 1, 0);
        add(0, 4'hF, 4'h3, 4'h1, 1, 8'h10,  1, 0, 4'h1, 1, 1, 0);
        add(0, 4'hF, 4'h2, 4'h2, 1, 8'h11,  1, 1, 4'h2, 1, 0, 1);
        // backpressure: ch1 frozen even when ch0 joins
        add(0, 4'hF, 4'h2, 4'h0, 0, 8'h40,  1, 1, 4'h0, 0, 0, 1);
        add(0, 4'hF, 4'h3, 4'h0, 0, 8'h40,  1, 1, 4'h0, 0, 1, 0);
        add(0, 4'hF, 4'h3, 4'h2, 1, 8'h40,  1, 1, 4'h2, 1, 1, 0);
        add(0, 4'hF, 4'h1, 4'h1, 1, 8'h41,  1, 0, 4'h1, 1, 0, 1);
        // ch1 disabled is never granted
        add(0, 4'hD, 4'h2, 4'h2, 1, 8'h42,  0, 1, 4'h0, 0, 0, 1);
        add(0, 4'hD, 4'h3, 4'h3, 1, 8'h43,  1, 0, 4'h1, 1, 0, 0);
        add(0, 4'hD, 4'h2, 4'h0, 1, 8'h44,  0, 1, 4'h0, 0, 0, 1);
        // ch_en[0] cleared mid-packet: ch0 packet still completes
        add(0, 4'hD, 4'h3, 4'h0, 1, 8'h45,  1, 0, 4'h1, 0, 0, 0);
        add(0, 4'hC, 4'h3, 4'h0, 1, 8'h46,  1, 0, 4'h1, 0, 1, 0);
        add(0, 4'hC, 4'h3, 4'h1, 1, 8'h47,  1, 0, 4'h1, 1, 1, 0);
        add(0, 4'hC, 4'h2, 4'h0, 1, 8'h48,  0, 1, 4'h0, 0, 0, 1);
        // rst during beat 2 of a ch3 packet; scan restarts at ch0
        add(0, 4'hF, 4'h8, 4'h0, 1, 8'h49,  1, 3, 4'h8, 0, 0, 0);
        add(1, 4'hF, 4'h8, 4'h0, 1, 8'h4A,  0, 3, 4'h0, 0, 1, 0);
        add(1, 4'hF, 4'h9, 4'h9, 1, 8'h4B,  0, 0, 4'h0, 0, 0, 0);
        add(0, 4'hF, 4'h9, 4'h9, 1, 8'h4C,  1, 0, 4'h1, 1, 0, 0);
        add(0, 4'hF, 4'h8, 4'h8, 1, 8'h4D,  1, 3, 4'h8, 1, 0, 1);
        add(0, 4'hF, 4'h0, 4'h0, 1, 8'h4E,  0, 0, 4'h0, 0, 0, 1);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].en, vq[i].vld, vq[i].lst, vq[i].rdy, vq[i].tag);
            @(negedge clk);
            chk("m_tvalid", i, 64'(m_tvalid), 64'(vq[i].e_mv));
            chk("m_chan",   i, 64'(m_chan),   64'(vq[i].e_ch));
            chk("s_tready", i, 64'(s_tready), 64'(vq[i].e_str));
            chk("busy",     i, 64'(busy),     64'(vq[i].e_busy));
            chk("pkt_done", i, 64'(pkt_done), 64'(vq[i].e_pd));
            if (vq[i].e_mv) begin
                chk("m_tlast", i, 64'(m_tlast), 64'(vq[i].e_ml));
                chk("m_tdata", i, 64'(m_tdata), 64'(mk_data(int'(vq[i].e_ch), vq[i].tag)));
                chk("m_tkeep", i, 64'(m_tkeep), 64'(mk_keep(int'(vq[i].e_ch), vq[i].tag)));
                chk("m_tuser", i, 64'(m_tuser), 64'(mk_user(int'(vq[i].e_ch), vq[i].tag)));
            end
            @(posedge clk);
            #1;
        end

        // long stall on ch2 while others pile up: beat must stay frozen
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'hF, (c == 0) ? 4'h4 : 4'hF, 4'h0, 1'b0, 8'h3C);
            @(negedge clk);
            chk("stall_chan",   100 + c, 64'(m_chan),   64'd2);
            chk("stall_valid",  100 + c, 64'(m_tvalid), 64'd1);
            chk("stall_data",   100 + c, 64'(m_tdata),  64'(mk_data(2, 8'h3C)));
            chk("stall_tready", 100 + c, 64'(s_tready), 64'h0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 4'hF, 4'hF, 4'h4, 1'b1, 8'h3C);
        @(negedge clk);
        chk("release_tready", 104, 64'(s_tready), 64'h4);
        chk("release_tlast",  104, 64'(m_tlast),  64'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 8'h3D);
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (pkt_done) seen = 1'b1;
            else @(posedge clk);
        end
        chk("pkt_done_seen", 105, 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 8'h3E);
        @(negedge clk);
        chk("after_stall_chan", 106, 64'(m_chan), 64'd3);
        chk("after_stall_busy", 106, 64'(busy),   64'd0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
